// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and helpers for the programmable clock-enable divider
package clkdiv_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 20;

    // Default reset divisor is the full-range value 2**w-1.
    function automatic logic [63:0] all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: counter, shadow divisor, pend flag, tick/sq registers
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int            DW      = DEF_DW,
    parameter logic [DW-1:0] RST_DIV = DW'(all_ones(DW))
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          adv,
    input  logic          sync,
    input  logic          wr,
    input  logic [DW-1:0] wr_div,
    output logic          boundary,
    output logic          pend,
    output logic          tick,
    output logic          sq
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] div_act;
    logic [DW-1:0] div_pend;

    // cnt never passes div_act, so the full-range divisor cannot overflow.
    assign boundary = adv & (cnt == div_act);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt      <= '0;
            div_act  <= RST_DIV;
            div_pend <= '0;
            pend     <= 1'b0;
            tick     <= 1'b0;
            sq       <= 1'b0;
        end else begin
            if (sync) begin
                cnt  <= '0;
                tick <= 1'b0;
                sq   <= 1'b0;
                if (pend) begin
                    div_act <= div_pend;
                end
                pend <= 1'b0;
            end else if (boundary) begin
                cnt  <= '0;
                tick <= 1'b1;
                sq   <= ~sq;
                if (pend) begin
                    div_act <= div_pend;
                end
                pend <= 1'b0;
            end else begin
                tick <= 1'b0;
                if (adv) begin
                    cnt <= cnt + DW'(1);
                end
            end
            // A write only lands while pend is clear, so it never clobbers an unapplied value.
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - N-channel programmable clock-enable generator; CLKDIV_CASCADE_EN chains channels
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int            NCH     = DEF_NCH,
    parameter int            DW      = DEF_DW,
    parameter logic [DW-1:0] RST_DIV = DW'(all_ones(DW)),
    localparam int           CHW     = ch_w(NCH)
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           en,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq
);

    logic [NCH-1:0]        adv;
    logic [NCH-1:0]        boundary;
    logic [NCH-1:0]        pend;
    logic [NCH-1:0]        wr;
    logic [(1<<CHW)-1:0]   pend_pad;
    logic                  accept;

    // Unused channel slots read as not-pending, so out-of-range targets are always ready.
    always_comb begin
        pend_pad          = '0;
        pend_pad[NCH-1:0] = pend;
    end

    assign cfg_ready = ~pend_pad[cfg_ch];
    assign accept    = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef CLKDIV_CASCADE_EN
        if (i == 0) begin : g_head
            assign adv[i] = en;
        end else begin : g_link
            assign adv[i] = boundary[i-1];
        end
`else
        assign adv[i] = en;
`endif
        assign wr[i] = accept & (cfg_ch == CHW'(i));

        clkdiv_chan #(
            .DW      (DW),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk      (clk),
            .arst_n   (arst_n),
            .adv      (adv[i]),
            .sync     (sync),
            .wr       (wr[i]),
            .wr_div   (cfg_div),
            .boundary (boundary[i]),
            .pend     (pend[i]),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb/tb_clkdiv_prog.sv - self-checking bench for clkdiv_prog
module tb_clkdiv_prog;

    localparam int NCH = 3;
    localparam int DW  = 4;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    always #5 clk = ~clk;

    clkdiv_prog #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .sq        (sq)
    );

    typedef struct {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
    } exp_t;

    typedef struct {
        bit en;
        bit tk;
        bit sq;
    } v2_t;

    typedef struct {
        bit t0;
        bit t2;
    } v4_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    int m_cnt [NCH];
    int m_act [NCH];
    int m_pv  [NCH];
    bit m_pend[NCH];
    bit m_sq  [NCH];
    bit m_tick[NCH];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_ready(input int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_act[i] = (1 << DW) - 1; m_pv[i] = 0;
            m_pend[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
        end
    endtask

    // Behavioural reference: expected state after one clock edge.
    task automatic m_clock(input bit e, input bit s, input bit v, input int ch, input int d);
        bit bnd[NCH];
        bit adv;
        bit wr;
        wr = v && (ch < NCH) && !m_pend[ch];
        for (int i = 0; i < NCH; i++) begin
            adv = e;
`ifdef CLKDIV_CASCADE_EN
            if (i > 0) adv = bnd[i-1];
`endif
            bnd[i] = adv && (m_cnt[i] == m_act[i]);
            if (s || bnd[i]) begin
                m_cnt[i]  = 0;
                m_tick[i] = !s;
                m_sq[i]   = s ? 1'b0 : !m_sq[i];
                if (m_pend[i]) m_act[i] = m_pv[i];
                m_pend[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (adv) m_cnt[i]++;
            end
            if (wr && ch == i) begin
                m_pv[i] = d; m_pend[i] = 1;
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input bit v, input int ch, input int d,
                        output bit rdy);
        exp_t x;
        en = e; sync = s; cfg_valid = v; cfg_ch = 2'(ch); cfg_div = 4'(d);
        #1;
        rdy = cfg_ready;
        chk("cfg_ready", int'(cfg_ready), int'(m_ready(ch)));
        m_clock(e, s, v, ch, d);
        for (int i = 0; i < NCH; i++) begin
            x.tick[i] = m_tick[i];
            x.sq[i]   = m_sq[i];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("tick", int'(tick), int'(x.tick));
        chk("sq", int'(sq), int'(x.sq));
    endtask

    task automatic run(input bit e);
        bit dummy;
        step(e, 1'b0, 1'b0, 0, 0, dummy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  r;
        int  g;
        v2_t t2[4];
        v4_t t4[8];
        t2 = '{'{1, 1, 1}, '{0, 0, 1}, '{1, 1, 0}, '{1, 1, 1}};
        t4 = '{'{0, 0}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}, '{1, 0}, '{0, 0}, '{1, 1}};

        m_reset();
        #3;
        chk("rst_tick", int'(tick), 0);
        chk("rst_sq", int'(sq), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        chk("rst_tick_hold", int'(tick), 0);
        arst_n = 1'b1;

`ifdef CLKDIV_CASCADE_EN
        step(1, 0, 1, 0, 1, r);
        step(1, 0, 1, 1, 2, r);
        step(1, 1, 0, 0, 0, r);
        for (int i = 0; i < 12; i++) begin
            run(1);
            chk("cas_tick0", int'(tick[0]), int'(i % 2 == 1));
            chk("cas_tick1", int'(tick[1]), int'(i % 6 == 5));
        end
`else
        // ch0 D=3 applied at the first reset-divisor boundary
        step(1, 0, 1, 0, 3, r);
        for (g = 0; g < 40; g++) begin
            run(1);
            if (tick[0]) break;
        end
        chk("t1_first_tick", int'(tick[0]), 1);
        chk("t1_sq_first", int'(sq[0]), 1);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                run(1);
                chk("t1_tick0", int'(tick[0]), int'(j == 3));
            end
        end
        chk("t1_sq_end", int'(sq[0]), 0);

        // ch1 D=0 applied through sync, then gated by en
        step(1, 0, 1, 1, 0, r);
        step(1, 1, 0, 0, 0, r);
        chk("t2_sync_tick", int'(tick), 0);
        chk("t2_sync_sq", int'(sq), 0);
        for (int i = 0; i < 4; i++) begin
            run(t2[i].en);
            chk("t2_tick1", int'(tick[1]), int'(t2[i].tk));
            chk("t2_sq1", int'(sq[1]), int'(t2[i].sq));
        end

        // ch2 back-to-back writes: second stalls until the boundary
        step(1, 0, 1, 2, 9, r);
        chk("t3_first_ready", int'(r), 1);
        for (g = 0; g < 40; g++) begin
            if (cfg_ready) chk("t3_ready_on_tick", int'(tick[2]), 1);
            step(1, 0, 1, 2, 2, r);
            if (g == 0) chk("t3_stall", int'(r), 0);
            if (r) break;
        end
        chk("t3_accepted", int'(r), 1);
        for (int j = 0; j < 9; j++) begin
            run(1);
            chk("t3_p10", int'(tick[2]), int'(j == 8));
        end
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                run(1);
                chk("t3_p3", int'(tick[2]), int'(j == 2));
            end
        end

        // sync mid-period with pending ch0 D=1, plus ch2 write in the sync cycle
        step(1, 0, 1, 0, 5, r);
        for (g = 0; g < 40; g++) begin
            run(1);
            if (tick[0]) break;
        end
        chk("t4_d5_tick", int'(tick[0]), 1);
        run(1);
        run(1);
        step(1, 0, 1, 0, 1, r);
        chk("t4_wr", int'(r), 1);
        step(1, 1, 1, 2, 4, r);
        chk("t4_sync_wr", int'(r), 1);
        chk("t4_sync_tick", int'(tick), 0);
        chk("t4_sync_sq", int'(sq), 0);
        for (int i = 0; i < 8; i++) begin
            run(1);
            chk("t4_tick0", int'(tick[0]), int'(t4[i].t0));
            chk("t4_tick2", int'(tick[2]), int'(t4[i].t2));
        end

        // out-of-range channel, then asynchronous reset mid-period
        step(1, 0, 1, 3, 0, r);
        chk("t5_oor_ready", int'(r), 1);
        run(1);
        run(1);
        arst_n = 1'b0;
        #1;
        chk("t5_rst_tick", int'(tick), 0);
        chk("t5_rst_sq", int'(sq), 0);
        chk("t5_rst_ready", int'(cfg_ready), 1);
        m_reset();
        sb.delete();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            run(1);
            chk("t5_rst_div", int'(tick[0]), int'(i % 16 == 15));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
